// File: rtl/db_defines.sv
// Shared constants and helpers for the deblocking-filter threshold front-end.
package db_defines;
  localparam int QP_MAX     = 51;
  localparam int OFFSET_MIN = -12;
  localparam int OFFSET_MAX = 12;

  localparam logic ID_LUMA   = 1'b0;
  localparam logic ID_CHROMA = 1'b1;

  typedef enum logic {MODE_IDLE, MODE_RUN} mode_e;

  function automatic int clip3(input int lo, input int hi, input int v);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction
endpackage

// File: rtl/db_rr_arb2.sv
// Two-way round-robin arbiter; last_r holds the most recent winner.
module db_rr_arb2
  import db_defines::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       gnt_id
);
  logic last_r;

  // Grants are suppressed while reset is held so ack stays low.
  always_comb begin
    gnt    = 2'b00;
    gnt_id = ID_LUMA;
    if (!rst) begin
      case (req)
        2'b01: begin gnt = 2'b01; gnt_id = ID_LUMA;   end
        2'b10: begin gnt = 2'b10; gnt_id = ID_CHROMA; end
        2'b11: begin
          gnt_id = ~last_r;
          gnt    = gnt_id ? 2'b10 : 2'b01;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
    if (rst)       last_r <= ID_CHROMA;
    else if (|gnt) last_r <= gnt_id;
  end
endmodule

// File: rtl/rom_alpha.sv
// Alpha' threshold table indexed by indexA; zero below index 16.
module rom_alpha #(
  parameter int QP_W = 6,
  parameter int TH_W = 8
) (
  input  logic [QP_W-1:0] addr,
  output logic [TH_W-1:0] data
);
  int v;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    v = 0;
    case (int'(addr))
      16, 17: v = 4;    18: v = 5;    19: v = 6;    20: v = 7;
      21: v = 8;        22: v = 9;    23: v = 10;   24: v = 12;
      25: v = 13;       26: v = 15;   27: v = 17;   28: v = 20;
      29: v = 22;       30: v = 25;   31: v = 28;   32: v = 32;
      33: v = 36;       34: v = 40;   35: v = 45;   36: v = 50;
      37: v = 56;       38: v = 63;   39: v = 71;   40: v = 80;
      41: v = 90;       42: v = 101;  43: v = 113;  44: v = 127;
      45: v = 144;      46: v = 162;  47: v = 182;  48: v = 203;
      49: v = 226;      50, 51: v = 255;
      default: v = 0;
    endcase
    data = TH_W'(v);
  end
endmodule

// File: rtl/rom_beta.sv
// Beta' threshold table indexed by indexB; zero below index 16.
module rom_beta #(
  parameter int QP_W = 6,
  parameter int TH_W = 8
) (
  input  logic [QP_W-1:0] addr,
  output logic [TH_W-1:0] data
);
  int v;

  always_comb begin
    v = 0;
    case (int'(addr)) inside
      [16:18]: v = 2;
      [19:22]: v = 3;
      [23:25]: v = 4;
      [26:27]: v = 6;
      [28:29]: v = 7;
      [30:31]: v = 8;
      [32:33]: v = 9;
      [34:35]: v = 10;
      [36:37]: v = 11;
      [38:39]: v = 12;
      [40:41]: v = 13;
      [42:43]: v = 14;
      [44:45]: v = 15;
      [46:47]: v = 16;
      [48:49]: v = 17;
      [50:51]: v = 18;
      default: v = 0;
    endcase
    data = TH_W'(v);
  end
endmodule

// File: rtl/db_thresh_arb.sv
// Shared alpha/beta lookup front-end for luma and chroma edge filters: arbitrate, average QP, offset, look up.
module db_thresh_arb
  import db_defines::*;
#(
  parameter int QP_W = 6,
  parameter int TH_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_load_i,
  input  logic [4:0]      offset_a_i,
  input  logic [4:0]      offset_b_i,
  input  logic [1:0]      req_i,
  input  logic [QP_W-1:0] qp_p0_i,
  input  logic [QP_W-1:0] qp_q0_i,
  input  logic [QP_W-1:0] qp_p1_i,
  input  logic [QP_W-1:0] qp_q1_i,
  output logic [1:0]      ack_o,
  output logic            res_valid_o,
  output logic            res_id_o,
  output logic [TH_W-1:0] alpha_o,
  output logic [TH_W-1:0] beta_o,
  output logic [QP_W-1:0] index_a_o,
  output logic            busy_o
);
  logic [1:0] gnt;
  logic       gnt_id;
  logic       grant;
  mode_e      mode;

  logic signed [4:0] off_a_r, off_b_r;

  logic [QP_W-1:0] qp_p, qp_q, qpav;
  logic [QP_W:0]   qp_sum;
  logic [QP_W-1:0] index_a_nxt, index_b_nxt;

  logic            v1, id1;
  logic [QP_W-1:0] index_a1, index_b1;
  logic [TH_W-1:0] rom_a, rom_b;

  logic            v2, id2;
  logic [TH_W-1:0] alpha2, beta2;
  logic [QP_W-1:0] index_a2;

  db_rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_i),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign grant  = |gnt;
  assign ack_o  = gnt;
  assign mode   = (v1 || v2 || grant) ? MODE_RUN : MODE_IDLE;
  assign busy_o = (mode == MODE_RUN);

  always_comb begin
    qp_p        = (gnt_id == ID_CHROMA) ? qp_p1_i : qp_p0_i;
    qp_q        = (gnt_id == ID_CHROMA) ? qp_q1_i : qp_q0_i;
    qp_sum      = {1'b0, qp_p} + {1'b0, qp_q} + (QP_W+1)'(1);
    qpav        = QP_W'(qp_sum >> 1);
    index_a_nxt = QP_W'(clip3(0, QP_MAX, int'(qpav) + int'(off_a_r)));
    index_b_nxt = QP_W'(clip3(0, QP_MAX, int'(qpav) + int'(off_b_r)));
  end

  // Offsets only change when nothing is in flight or about to be granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_a_r <= '0;
      off_b_r <= '0;
    end else if (cfg_load_i && !busy_o && !(|req_i)) begin
      off_a_r <= offset_a_i;
      off_b_r <= offset_b_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1       <= 1'b0;
      id1      <= ID_LUMA;
      index_a1 <= '0;
      index_b1 <= '0;
    end else begin
      v1 <= grant;
      if (grant) begin
        id1      <= gnt_id;
        index_a1 <= index_a_nxt;
        index_b1 <= index_b_nxt;
      end
    end
  end

  rom_alpha #(.QP_W(QP_W), .TH_W(TH_W)) u_rom_alpha (.addr(index_a1), .data(rom_a));
  rom_beta  #(.QP_W(QP_W), .TH_W(TH_W)) u_rom_beta  (.addr(index_b1), .data(rom_b));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2       <= 1'b0;
      id2      <= ID_LUMA;
      alpha2   <= '0;
      beta2    <= '0;
      index_a2 <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        id2      <= id1;
        alpha2   <= rom_a;
        beta2    <= rom_b;
        index_a2 <= index_a1;
      end
    end
  end

  assign res_valid_o = v2;
  assign res_id_o    = id2;
  assign alpha_o     = alpha2;
  assign beta_o      = beta2;
  assign index_a_o   = index_a2;
endmodule
